// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit configuration: address/instruction widths, reset PC and FSM states.
// Optional build macro consumed by ifu_fetch: IFU_MISALIGN_CHK_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

package ifu_fetch_pkg;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int INST_W = `INST_WIDTH;

    localparam logic [ADDR_W-1:0] RST_PC_DEF = ADDR_W'(32'h8000_0000);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding memory requests, valid/ready toward decode, redirect flush.
// Build option IFU_MISALIGN_CHK_EN adds o_ifu_exc_misalign and parks the unit on misaligned redirects.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] RST_PC  = RST_PC_DEF,
    parameter int unsigned            PC_STEP = 4
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    output logic                    o_ifu_mem_req,
    input  logic                    i_mem_ifu_gnt,
    output logic [`ADDR_WIDTH-1:0]  o_ifu_mem_addr,
    input  logic                    i_mem_ifu_rsp,
    input  logic [`INST_WIDTH-1:0]  i_mem_ifu_inst,
    output logic                    o_sys_valid,
    input  logic                    i_sys_ready,
    output logic [`INST_WIDTH-1:0]  o_ifu_inst,
    output logic [`ADDR_WIDTH-1:0]  o_ifu_pc,
    input  logic                    i_exu_jmp_en,
    input  logic [`ADDR_WIDTH-1:0]  i_exu_jmp_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                    o_ifu_exc_misalign
`endif
);

    fetch_state_t          state;
    logic [ADDR_W-1:0]     r_pc;
    logic                  r_drop;
    logic [ADDR_W-1:0]     jmp_tgt;
    logic                  jmp_bad;
    logic                  in_flight;

`ifdef IFU_MISALIGN_CHK_EN
    logic r_exc;
    assign jmp_tgt            = i_exu_jmp_pc;
    assign jmp_bad            = |i_exu_jmp_pc[1:0];
    assign o_ifu_exc_misalign = r_exc;
`else
    assign jmp_tgt = align_pc(i_exu_jmp_pc);
    assign jmp_bad = 1'b0;
`endif

    assign o_ifu_mem_addr = r_pc;

    // A response is still owed to us after this edge: granted now, or awaited and not arriving now.
    assign in_flight = (o_ifu_mem_req && i_mem_ifu_gnt)
                    || (state == WAIT && !i_mem_ifu_rsp)
                    || (state == IDLE && r_drop && !i_mem_ifu_rsp);

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state         <= IDLE;
            r_pc          <= RST_PC;
            r_drop        <= 1'b0;
            o_ifu_mem_req <= 1'b0;
            o_sys_valid   <= 1'b0;
            o_ifu_inst    <= '0;
            o_ifu_pc      <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            r_exc         <= 1'b0;
`endif
        end else if (i_exu_jmp_en) begin
            r_pc        <= jmp_tgt;
            o_sys_valid <= 1'b0;
            r_drop      <= in_flight;
            if (jmp_bad) begin
                state         <= IDLE;
                o_ifu_mem_req <= 1'b0;
            end else if (in_flight) begin
                state         <= WAIT;
                o_ifu_mem_req <= 1'b0;
            end else begin
                state         <= REQ;
                o_ifu_mem_req <= 1'b1;
            end
`ifdef IFU_MISALIGN_CHK_EN
            r_exc <= jmp_bad;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef IFU_MISALIGN_CHK_EN
                    if (i_mem_ifu_rsp) begin
                        r_drop <= 1'b0;
                    end
                    if (!r_exc) begin
                        state         <= REQ;
                        o_ifu_mem_req <= 1'b1;
                    end
`else
                    state         <= REQ;
                    o_ifu_mem_req <= 1'b1;
`endif
                end
                REQ: begin
                    if (i_mem_ifu_gnt) begin
                        state         <= WAIT;
                        o_ifu_mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (i_mem_ifu_rsp) begin
                        if (r_drop) begin
                            r_drop        <= 1'b0;
                            state         <= REQ;
                            o_ifu_mem_req <= 1'b1;
                        end else begin
                            o_ifu_inst  <= i_mem_ifu_inst;
                            o_ifu_pc    <= r_pc;
                            o_sys_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (i_sys_ready) begin
                        o_sys_valid   <= 1'b0;
                        r_pc          <= r_pc + ADDR_W'(PC_STEP);
                        state         <= REQ;
                        o_ifu_mem_req <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    o_ifu_mem_req <= 1'b0;
                    o_sys_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: memory responder, PC-stream reference model, directed redirect/stall scenarios.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   o_ifu_mem_req;
    logic                   i_mem_ifu_gnt;
    logic [`ADDR_WIDTH-1:0] o_ifu_mem_addr;
    logic                   i_mem_ifu_rsp;
    logic [`INST_WIDTH-1:0] i_mem_ifu_inst;
    logic                   o_sys_valid;
    logic                   i_sys_ready;
    logic [`INST_WIDTH-1:0] o_ifu_inst;
    logic [`ADDR_WIDTH-1:0] o_ifu_pc;
    logic                   i_exu_jmp_en;
    logic [`ADDR_WIDTH-1:0] i_exu_jmp_pc;
`ifdef IFU_MISALIGN_CHK_EN
    logic                   o_ifu_exc_misalign;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] model_pc;

    logic        gnt_en;
    int          rsp_lat;
    bit          stale_en;
    bit          pend;
    int          due;
    logic [31:0] pend_word;

    ifu_fetch #(.RST_PC(32'h8000_0000), .PC_STEP(4)) dut (
        .i_sys_clk      (clk),
        .i_sys_rst_n    (rst_n),
        .o_ifu_mem_req  (o_ifu_mem_req),
        .i_mem_ifu_gnt  (i_mem_ifu_gnt),
        .o_ifu_mem_addr (o_ifu_mem_addr),
        .i_mem_ifu_rsp  (i_mem_ifu_rsp),
        .i_mem_ifu_inst (i_mem_ifu_inst),
        .o_sys_valid    (o_sys_valid),
        .i_sys_ready    (i_sys_ready),
        .o_ifu_inst     (o_ifu_inst),
        .o_ifu_pc       (o_ifu_pc),
        .i_exu_jmp_en   (i_exu_jmp_en),
        .i_exu_jmp_pc   (i_exu_jmp_pc)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .o_ifu_exc_misalign (o_ifu_exc_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Memory image: the reset vector holds a NOP, everything else is a recognisable address hash.
    function automatic logic [31:0] inst_for(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic logic [31:0] redirect_target(input logic [31:0] t);
`ifdef IFU_MISALIGN_CHK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare against the model mid-cycle, drive the memory side, advance the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (o_sys_valid) begin
                check("model_pc", o_ifu_pc, model_pc);
                check("model_inst", o_ifu_inst, inst_for(model_pc));
                check("model_no_req_in_hold", 32'(o_ifu_mem_req), 32'd0);
            end
            if (o_ifu_mem_req) begin
                check("model_req_addr", o_ifu_mem_addr, model_pc);
            end
        end
        i_mem_ifu_rsp  = 1'b0;
        i_mem_ifu_inst = 32'hDEADBEEF;
        if (pend && due == cyc) begin
            i_mem_ifu_rsp  = 1'b1;
            i_mem_ifu_inst = pend_word;
            pend           = 1'b0;
        end
        i_mem_ifu_gnt = gnt_en;
        if (o_ifu_mem_req && gnt_en) begin
            check("single_outstanding", 32'(pend), 32'd0);
            pend      = 1'b1;
            due       = cyc + rsp_lat;
            pend_word = stale_en ? 32'hDEADBEEF : inst_for(o_ifu_mem_addr);
            stale_en  = 1'b0;
        end
        if (!rst_n) begin
            model_pc = RST_PC;
        end else if (i_exu_jmp_en) begin
            model_pc = redirect_target(i_exu_jmp_pc);
        end else if (o_sys_valid && i_sys_ready) begin
            model_pc = model_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_sys_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid_seen"}, 32'(o_sys_valid), 32'd1);
    endtask

    task automatic jump(input logic [31:0] target);
        i_exu_jmp_en = 1'b1;
        i_exu_jmp_pc = target;
        tick();
        i_exu_jmp_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc0;
        logic [31:0] inst0;
        rst_n          = 1'b0;
        i_sys_ready    = 1'b1;
        i_exu_jmp_en   = 1'b0;
        i_exu_jmp_pc   = '0;
        i_mem_ifu_gnt  = 1'b0;
        i_mem_ifu_rsp  = 1'b0;
        i_mem_ifu_inst = '0;
        gnt_en         = 1'b1;
        rsp_lat        = 1;
        stale_en       = 1'b0;
        pend           = 1'b0;
        due            = 0;
        pend_word      = '0;
        model_pc       = RST_PC;

        repeat (3) tick();
        check("rst_req", 32'(o_ifu_mem_req), 32'd0);
        check("rst_valid", 32'(o_sys_valid), 32'd0);
        check("rst_inst", o_ifu_inst, 32'd0);
        check("rst_pc", o_ifu_pc, 32'd0);
        check("rst_addr", o_ifu_mem_addr, 32'h8000_0000);

        // Reset release: one dead cycle, request in cycle 1, valid in cycle 3.
        rst_n = 1'b1;
        check("idle_req", 32'(o_ifu_mem_req), 32'd0);
        tick();
        check("c1_req", 32'(o_ifu_mem_req), 32'd1);
        check("c1_addr", o_ifu_mem_addr, 32'h8000_0000);
        tick();
        check("c2_req", 32'(o_ifu_mem_req), 32'd0);
        check("c2_valid", 32'(o_sys_valid), 32'd0);
        tick();
        check("c3_valid", 32'(o_sys_valid), 32'd1);
        check("c3_pc", o_ifu_pc, 32'h8000_0000);
        check("c3_inst", o_ifu_inst, 32'h0000_0013);
        tick();
        check("c4_req", 32'(o_ifu_mem_req), 32'd1);
        check("c4_addr", o_ifu_mem_addr, 32'h8000_0004);
        check("c4_valid", 32'(o_sys_valid), 32'd0);

        // Decode back-pressure for 5 cycles.
        i_sys_ready = 1'b0;
        wait_valid("stall");
        check("stall_pc", o_ifu_pc, 32'h8000_0004);
        pc0   = o_ifu_pc;
        inst0 = o_ifu_inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_valid", 32'(o_sys_valid), 32'd1);
            check("stall_hold_pc", o_ifu_pc, pc0);
            check("stall_hold_inst", o_ifu_inst, inst0);
            check("stall_no_req", 32'(o_ifu_mem_req), 32'd0);
        end
        i_sys_ready = 1'b1;
        tick();
        check("stall_release_valid", 32'(o_sys_valid), 32'd0);
        check("stall_release_req", 32'(o_ifu_mem_req), 32'd1);
        check("stall_release_addr", o_ifu_mem_addr, 32'h8000_0008);

        // Redirect while waiting; the stale DEADBEEF response lands two cycles later.
        stale_en = 1'b1;
        rsp_lat  = 3;
        tick();
        check("wait_req_low", 32'(o_ifu_mem_req), 32'd0);
        jump(32'h8000_0100);
        check("stale_w2_req", 32'(o_ifu_mem_req), 32'd0);
        check("stale_w2_valid", 32'(o_sys_valid), 32'd0);
        tick();
        check("stale_w3_req", 32'(o_ifu_mem_req), 32'd0);
        check("stale_w3_valid", 32'(o_sys_valid), 32'd0);
        tick();
        check("stale_refetch_req", 32'(o_ifu_mem_req), 32'd1);
        check("stale_refetch_addr", o_ifu_mem_addr, 32'h8000_0100);
        check("stale_refetch_valid", 32'(o_sys_valid), 32'd0);
        rsp_lat = 1;
        wait_valid("after_stale");
        check("after_stale_pc", o_ifu_pc, 32'h8000_0100);
        check("after_stale_inst", o_ifu_inst, 32'h25A5_0100);

        // Redirect coinciding with a completed HOLD handshake: target wins over pc+4.
        jump(32'h8000_0200);
        check("hold_jmp_req", 32'(o_ifu_mem_req), 32'd1);
        check("hold_jmp_addr", o_ifu_mem_addr, 32'h8000_0200);
        check("hold_jmp_valid", 32'(o_sys_valid), 32'd0);
        wait_valid("hold_jmp");
        check("hold_jmp_pc", o_ifu_pc, 32'h8000_0200);

        // Redirect in the same cycle the request is granted.
        tick();
        check("req_gnt_pre_addr", o_ifu_mem_addr, 32'h8000_0204);
        jump(32'h8000_0300);
        check("req_gnt_wait", 32'(o_ifu_mem_req), 32'd0);
        tick();
        check("req_gnt_refetch_req", 32'(o_ifu_mem_req), 32'd1);
        check("req_gnt_refetch_addr", o_ifu_mem_addr, 32'h8000_0300);
        wait_valid("req_gnt");
        check("req_gnt_pc", o_ifu_pc, 32'h8000_0300);
        check("req_gnt_inst", o_ifu_inst, 32'h25A5_0300);

        // Redirect in the same cycle the response arrives.
        tick();
        check("wait_rsp_pre_addr", o_ifu_mem_addr, 32'h8000_0304);
        tick();
        jump(32'h8000_0400);
        check("wait_rsp_req", 32'(o_ifu_mem_req), 32'd1);
        check("wait_rsp_addr", o_ifu_mem_addr, 32'h8000_0400);
        check("wait_rsp_valid", 32'(o_sys_valid), 32'd0);
        wait_valid("wait_rsp");
        check("wait_rsp_pc", o_ifu_pc, 32'h8000_0400);

        // Grant withheld for 4 cycles, then PC wraps at the top of the address space.
        gnt_en = 1'b0;
        jump(32'hFFFF_FFFC);
        check("nogrant_req", 32'(o_ifu_mem_req), 32'd1);
        check("nogrant_addr", o_ifu_mem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nogrant_hold_req", 32'(o_ifu_mem_req), 32'd1);
            check("nogrant_hold_addr", o_ifu_mem_addr, 32'hFFFF_FFFC);
        end
        gnt_en = 1'b1;
        wait_valid("wrap");
        check("wrap_pc", o_ifu_pc, 32'hFFFF_FFFC);
        check("wrap_inst", o_ifu_inst, 32'h5A5A_FFFC);
        tick();
        check("wrap_req", 32'(o_ifu_mem_req), 32'd1);
        check("wrap_addr", o_ifu_mem_addr, 32'h0000_0000);

`ifdef IFU_MISALIGN_CHK_EN
        // Misaligned redirect parks the unit until an aligned redirect.
        wait_valid("pre_misalign");
        jump(32'h8000_0102);
        check("misalign_exc", 32'(o_ifu_exc_misalign), 32'd1);
        check("misalign_valid", 32'(o_sys_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("misalign_no_req", 32'(o_ifu_mem_req), 32'd0);
            check("misalign_exc_held", 32'(o_ifu_exc_misalign), 32'd1);
        end
        jump(32'h8000_0104);
        check("realign_exc", 32'(o_ifu_exc_misalign), 32'd0);
        check("realign_req", 32'(o_ifu_mem_req), 32'd1);
        check("realign_addr", o_ifu_mem_addr, 32'h8000_0104);
        wait_valid("realign");
        check("realign_pc", o_ifu_pc, 32'h8000_0104);
`else
        // Low target bits are dropped.
        wait_valid("pre_align");
        jump(32'h8000_0502);
        check("align_req", 32'(o_ifu_mem_req), 32'd1);
        check("align_addr", o_ifu_mem_addr, 32'h8000_0500);
        wait_valid("align");
        check("align_pc", o_ifu_pc, 32'h8000_0500);
`endif

        // Reset while a response is outstanding: it lands during reset and is ignored.
        tick();
        tick();
        check("midrst_wait_req", 32'(o_ifu_mem_req), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_req", 32'(o_ifu_mem_req), 32'd0);
        check("midrst_valid", 32'(o_sys_valid), 32'd0);
        check("midrst_pc", o_ifu_pc, 32'd0);
        check("midrst_addr", o_ifu_mem_addr, 32'h8000_0000);
        tick();
        check("midrst_c1_req", 32'(o_ifu_mem_req), 32'd1);
        check("midrst_c1_addr", o_ifu_mem_addr, 32'h8000_0000);
        wait_valid("midrst");
        check("midrst_fetch_pc", o_ifu_pc, 32'h8000_0000);
        check("midrst_fetch_inst", o_ifu_inst, 32'h0000_0013);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
